// File: rtl/bpsk_pkg.sv
// Shared BPSK definitions for the modulator and demodulator: midscale constant, FSM
// state encoding, accumulator width derivation and the offset-binary conversion.
package bpsk_pkg;

    localparam int unsigned SineWidth = 12;
    localparam logic [SineWidth-1:0] Midscale = 12'h800;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    function automatic int unsigned acc_width(int unsigned sine_w, int unsigned cnt_w);
        return sine_w + cnt_w + 1;
    endfunction

    // Offset-binary <-> two's complement; the mapping is its own inverse.
    function automatic logic [SineWidth-1:0] offset_flip(logic [SineWidth-1:0] x);
        return x ^ Midscale;
    endfunction

endpackage

// File: rtl/bpsk_demodulator_if.sv
// Sample-in / frame-out bundle of the BPSK demodulator. The master side is the sample
// source and frame consumer; the slave side is the demodulator.
interface bpsk_demodulator_if #(
    parameter int unsigned SINE_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  en;
    logic                  sync;
    logic [SINE_WIDTH-1:0] signal_in;
    logic [DATA_WIDTH:0]   out;
    logic                  out_valid;
    logic                  erasure;

    modport master (
        output en, sync, signal_in,
        input  out, out_valid, erasure
    );

    modport slave (
        input  en, sync, signal_in,
        output out, out_valid, erasure
    );
endinterface

// File: rtl/bpsk_correlator.sv
// Multiply-free correlator: accumulates +/- samples against a square-wave carrier
// replica and gives a sign decision (and, with BPSK_DEMOD_ERASURE_EN, a low-magnitude flag).
module bpsk_correlator
    import bpsk_pkg::*;
#(
    parameter int unsigned SINE_WIDTH   = 12,
    parameter int unsigned SAMPLE_CNT_W = 8,
    parameter int unsigned THRESH       = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic                  neg_i,
    input  logic                  last_i,
    input  logic [SINE_WIDTH-1:0] sample_i,
`ifdef BPSK_DEMOD_ERASURE_EN
    output logic                  low_mag_o,
`endif
    output logic                  bit_o
);
    localparam int unsigned AccW = acc_width(SINE_WIDTH, SAMPLE_CNT_W);

    logic signed [SINE_WIDTH-1:0] s;
    logic signed [AccW-1:0]       s_ext, contrib, sum, acc_q, acc_d;

    always_comb begin
        s       = signed'(sample_i ^ {1'b1, {(SINE_WIDTH-1){1'b0}}});
        s_ext   = {{(AccW-SINE_WIDTH){s[SINE_WIDTH-1]}}, s};
        contrib = neg_i ? -s_ext : s_ext;
        sum     = acc_q + contrib;
        acc_d   = acc_q;
        // A sync restarts the bit with the current sample as its first contribution.
        if (clr_i) begin
            acc_d = en_i ? contrib : '0;
        end else if (en_i) begin
            acc_d = last_i ? '0 : sum;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign bit_o = sum[AccW-1];

`ifdef BPSK_DEMOD_ERASURE_EN
    logic [AccW-1:0] mag;
    always_comb begin
        mag       = sum[AccW-1] ? AccW'(-sum) : AccW'(sum);
        low_mag_o = mag < AccW'(THRESH);
    end
`endif

endmodule

// File: rtl/bpsk_demodulator.sv
// Coherent BPSK demodulator top: sample/bit counters, IDLE/RUN FSM, frame shift register
// and output registers. Define BPSK_DEMOD_ERASURE_EN to enable the per-frame erasure flag.
module bpsk_demodulator
    import bpsk_pkg::*;
#(
    parameter int unsigned SINE_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned SAMPLE_CNT_W = 8,
    parameter int unsigned THRESH       = 1024
) (
    input logic               clk,
    input logic               arst,
    bpsk_demodulator_if.slave bus
);
    localparam int unsigned FrameBits = DATA_WIDTH + 1;
    localparam int unsigned BitCntW   = $clog2(FrameBits);

    state_e                    state_q, state_d;
    logic                      consume, last_sample, last_bit, neg, dec_bit;
    logic [SAMPLE_CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic [BitCntW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [FrameBits-1:0]      shreg_q, shreg_d, out_q, out_d;
    logic                      out_valid_q, out_valid_d;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.en || bus.sync) state_d = StRun;
            StRun:   state_d = StRun;
        endcase
    end

    // Counters start at zero in IDLE, so the first qualified sample is sample 0 of bit 0.
    always_comb begin
        consume = bus.en;
    end

    assign last_sample = &sample_cnt_q;
    assign last_bit    = bit_cnt_q == BitCntW'(FrameBits - 1);
    assign neg         = !bus.sync && sample_cnt_q[SAMPLE_CNT_W-1];

`ifdef BPSK_DEMOD_ERASURE_EN
    logic low_mag;
`endif

    bpsk_correlator #(
        .SINE_WIDTH  (SINE_WIDTH),
        .SAMPLE_CNT_W(SAMPLE_CNT_W),
        .THRESH      (THRESH)
    ) u_corr (
        .clk_i    (clk),
        .rst_ni   (arst),
        .en_i     (consume),
        .clr_i    (bus.sync),
        .neg_i    (neg),
        .last_i   (last_sample),
        .sample_i (bus.signal_in),
`ifdef BPSK_DEMOD_ERASURE_EN
        .low_mag_o(low_mag),
`endif
        .bit_o    (dec_bit)
    );

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        out_d        = out_q;
        out_valid_d  = 1'b0;
        if (bus.sync) begin
            sample_cnt_d = SAMPLE_CNT_W'(bus.en);
            bit_cnt_d    = '0;
            shreg_d      = '0;
        end else if (consume) begin
            sample_cnt_d = sample_cnt_q + 1'b1;
            if (last_sample) begin
                shreg_d = {shreg_q[FrameBits-2:0], dec_bit};
                if (last_bit) begin
                    bit_cnt_d   = '0;
                    out_d       = shreg_d;
                    out_valid_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

`ifdef BPSK_DEMOD_ERASURE_EN
    logic flag_q, flag_d, erasure_q, erasure_d;

    always_comb begin
        flag_d    = flag_q;
        erasure_d = erasure_q;
        if (bus.sync) begin
            flag_d = 1'b0;
        end else if (consume && last_sample) begin
            if (last_bit) begin
                erasure_d = flag_q || low_mag;
                flag_d    = 1'b0;
            end else begin
                flag_d = flag_q || low_mag;
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            flag_q    <= 1'b0;
            erasure_q <= 1'b0;
        end else begin
            flag_q    <= flag_d;
            erasure_q <= erasure_d;
        end
    end

    assign bus.erasure = erasure_q;
`else
    assign bus.erasure = 1'b0;
`endif

endmodule
